// File: rtl/ball_game_ctrl_if.sv
// Bundles the ball-side status inputs, scan position and game outputs of
// ball_game_ctrl. The controller connects through the slave modport; the
// environment (VGA timing, ball, buttons) drives it through master.
//
// Handshake: there is no valid/ready pair on this bus. Every input is sampled
// on each rising clk edge. Every output is a registered level, except move,
// which is a single-clk strobe.
interface ball_game_ctrl_if;
  logic       pixpulse;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] xloc;
  logic       player;
  logic       broken0;
  logic       broken1;
  logic       start;
  logic       move;
  logic       ball_reset;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [7:0] blocks0;
  logic [7:0] blocks1;
  logic [7:0] speed;
  logic       serve_player;
  logic       game_over;
  logic       winner;
  logic [2:0] state_dbg;

  modport slave (
    input  pixpulse, hcount, vcount, xloc, player, broken0, broken1, start,
    output move, ball_reset, score0, score1, blocks0, blocks1, speed,
           serve_player, game_over, winner, state_dbg
  );

  modport master (
    output pixpulse, hcount, vcount, xloc, player, broken0, broken1, start,
    input  move, ball_reset, score0, score1, blocks0, blocks1, speed,
           serve_player, game_over, winner, state_dbg
  );
endinterface

// File: rtl/ball_game_ctrl.sv
// Game sequencer for the ball block. It paces the ball with a per-frame move
// strobe, holds the ball in reset while serving, detects goals, keeps scores
// and broken-block counts, and runs the serve/play/point/over flow.
//
// Timing notes:
//   - frame_tick is the pixpulse at hcount==0, vcount==FRAME_LINE.
//   - The move decision is computed one pixpulse earlier, at hcount==639 and
//     vcount==FRAME_LINE-1. It is held in mv_pend_q/acc_pend_q and committed
//     on frame_tick, so move is high for exactly the one clk after the tick.
//   - A goal seen on a tick suppresses that frame's move and leaves the
//     accumulator untouched.
// state_dbg encoding: 0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER.
module ball_game_ctrl #(
  parameter logic [9:0] LEFT_GOAL    = 10'd4,
  parameter logic [9:0] RIGHT_GOAL   = 10'd635,
  parameter logic [9:0] FRAME_LINE   = 10'd480,
  parameter logic [7:0] SERVE_FRAMES = 8'd60,
  parameter logic [7:0] SPEED_INIT   = 8'd128,
  parameter logic [7:0] SPEED_STEP   = 8'd16,
  parameter logic [3:0] RALLY_HITS   = 4'd4,
  parameter logic [3:0] WIN_SCORE    = 4'd7
) (
  input  logic              clk,
  input  logic              rst,
  ball_game_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic       player_q, player_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] acc_pend_q, acc_pend_d;
  logic       mv_pend_q, mv_pend_d;
  logic [7:0] speed_q, speed_d;
  logic [3:0] rally_q, rally_d;
  logic [3:0] score0_q, score0_d;
  logic [3:0] score1_q, score1_d;
  logic [7:0] blocks0_q, blocks0_d;
  logic [7:0] blocks1_q, blocks1_d;
  logic       scorer_q, scorer_d;
  logic       serve_player_q, serve_player_d;
  logic       winner_q, winner_d;
  logic       game_over_q, game_over_d;
  logic       ball_reset_q, ball_reset_d;
  logic       move_q, move_d;

  logic       frame_tick;
  logic       pre_tick;
  logic       start_rise;
  logic [8:0] acc9;
  logic [8:0] speed_sum;
  logic [7:0] speed_sat;
  logic [3:0] new_score;

  // Scan-position decodes and datapath helpers shared by the next-state logic.
  always_comb begin
    frame_tick = bus.pixpulse && (bus.hcount == 10'd0) && (bus.vcount == FRAME_LINE);
    pre_tick   = bus.pixpulse && (bus.hcount == 10'd639) &&
                 (bus.vcount == (FRAME_LINE - 10'd1));
    start_rise = bus.start && !start_q;
    acc9       = {1'b0, acc_q} + {1'b0, speed_q};
    speed_sum  = {1'b0, speed_q} + {1'b0, SPEED_STEP};
    speed_sat  = speed_sum[8] ? 8'hFF : speed_sum[7:0];
    new_score  = scorer_q ? (score1_q + 4'd1) : (score0_q + 4'd1);
  end

  // Next-state and next-output computation for the game FSM and its counters.
  always_comb begin
    state_d        = state_q;
    start_d        = bus.start;
    player_d       = bus.player;
    serve_cnt_d    = serve_cnt_q;
    acc_d          = acc_q;
    acc_pend_d     = acc_pend_q;
    mv_pend_d      = mv_pend_q;
    speed_d        = speed_q;
    rally_d        = rally_q;
    score0_d       = score0_q;
    score1_d       = score1_q;
    blocks0_d      = blocks0_q;
    blocks1_d      = blocks1_q;
    scorer_d       = scorer_q;
    serve_player_d = serve_player_q;
    winner_d       = winner_q;
    game_over_d    = game_over_q;
    ball_reset_d   = ball_reset_q;
    move_d         = 1'b0;

    // Lookahead: decide the coming frame's move one pixpulse before the tick.
    if (pre_tick) begin
      mv_pend_d  = acc9[8];
      acc_pend_d = acc9[7:0];
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        ball_reset_d = 1'b1;
        if (start_rise) begin
          score0_d       = 4'd0;
          score1_d       = 4'd0;
          blocks0_d      = 8'd0;
          blocks1_d      = 8'd0;
          serve_player_d = 1'b0;
          game_over_d    = 1'b0;
          serve_cnt_d    = SERVE_FRAMES;
          state_d        = ST_SERVE;
        end
      end

      ST_SERVE: begin
        ball_reset_d = 1'b1;
        if (frame_tick) begin
          // Loading 0 wraps through 255, giving a 256-frame serve.
          serve_cnt_d = serve_cnt_q - 8'd1;
          if (serve_cnt_q == 8'd1) begin
            state_d      = ST_PLAY;
            ball_reset_d = 1'b0;
            speed_d      = SPEED_INIT;
            acc_d        = 8'd0;
            rally_d      = 4'd0;
          end
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          if (bus.xloc < LEFT_GOAL) begin
            scorer_d = 1'b1;
            state_d  = ST_POINT;
          end else if (bus.xloc > RIGHT_GOAL) begin
            scorer_d = 1'b0;
            state_d  = ST_POINT;
          end else begin
            move_d = mv_pend_q;
            acc_d  = acc_pend_q;
          end
        end
        if (bus.player != player_q) begin
          if (rally_q == (RALLY_HITS - 4'd1)) begin
            rally_d = 4'd0;
            speed_d = speed_sat;
          end else begin
            rally_d = rally_q + 4'd1;
          end
        end
        if (bus.broken0 && (blocks0_q != 8'hFF)) blocks0_d = blocks0_q + 8'd1;
        if (bus.broken1 && (blocks1_q != 8'hFF)) blocks1_d = blocks1_q + 8'd1;
      end

      ST_POINT: begin
        if (scorer_q) score1_d = new_score;
        else          score0_d = new_score;
        serve_player_d = !scorer_q;
        ball_reset_d   = 1'b1;
        if (new_score == WIN_SCORE) begin
          winner_d    = scorer_q;
          game_over_d = 1'b1;
          state_d     = ST_OVER;
        end else begin
          serve_cnt_d = SERVE_FRAMES;
          state_d     = ST_SERVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // All state and outputs are registered; rst clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      start_q        <= 1'b0;
      player_q       <= 1'b0;
      serve_cnt_q    <= 8'd0;
      acc_q          <= 8'd0;
      acc_pend_q     <= 8'd0;
      mv_pend_q      <= 1'b0;
      speed_q        <= SPEED_INIT;
      rally_q        <= 4'd0;
      score0_q       <= 4'd0;
      score1_q       <= 4'd0;
      blocks0_q      <= 8'd0;
      blocks1_q      <= 8'd0;
      scorer_q       <= 1'b0;
      serve_player_q <= 1'b0;
      winner_q       <= 1'b0;
      game_over_q    <= 1'b0;
      ball_reset_q   <= 1'b1;
      move_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      player_q       <= player_d;
      serve_cnt_q    <= serve_cnt_d;
      acc_q          <= acc_d;
      acc_pend_q     <= acc_pend_d;
      mv_pend_q      <= mv_pend_d;
      speed_q        <= speed_d;
      rally_q        <= rally_d;
      score0_q       <= score0_d;
      score1_q       <= score1_d;
      blocks0_q      <= blocks0_d;
      blocks1_q      <= blocks1_d;
      scorer_q       <= scorer_d;
      serve_player_q <= serve_player_d;
      winner_q       <= winner_d;
      game_over_q    <= game_over_d;
      ball_reset_q   <= ball_reset_d;
      move_q         <= move_d;
    end
  end

  assign bus.move         = move_q;
  assign bus.ball_reset   = ball_reset_q;
  assign bus.score0       = score0_q;
  assign bus.score1       = score1_q;
  assign bus.blocks0      = blocks0_q;
  assign bus.blocks1      = blocks1_q;
  assign bus.speed        = speed_q;
  assign bus.serve_player = serve_player_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Directed bench for ball_game_ctrl. Frames are compressed: each one is a
// lookahead pixpulse at (639, 479), three idle clks, the tick pixpulse at
// (0, 480) and three more idle clks.
module tb_ball_game_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   stray;
  logic [0:0] exp_q[$];

  ball_game_ctrl_if bif ();

  ball_game_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One compressed frame. mv/st are sampled one clk after the tick edge,
  // br1 one clk later. Any move seen elsewhere is counted as stray.
  task automatic frame(output logic mv, output logic [2:0] st, output logic br1);
    bif.pixpulse = 1'b1; bif.hcount = 10'd639; bif.vcount = 10'd479;
    step();
    if (bif.move) stray++;
    bif.pixpulse = 1'b0;
    repeat (3) begin step(); if (bif.move) stray++; end
    bif.pixpulse = 1'b1; bif.hcount = 10'd0; bif.vcount = 10'd480;
    step();
    mv = bif.move;
    st = bif.state_dbg;
    bif.pixpulse = 1'b0; bif.hcount = 10'd1;
    step();
    br1 = bif.ball_reset;
    if (bif.move) stray++;
    repeat (2) begin step(); if (bif.move) stray++; end
  endtask

  // Serve frames must never issue a move.
  task automatic serve_frames(input int n);
    logic mv, br;
    logic [2:0] st;
    for (int i = 0; i < n; i++) begin
      frame(mv, st, br);
      if (mv) stray++;
    end
  endtask

  task automatic pulse_start();
    bif.start = 1'b1; step();
    bif.start = 1'b0; step();
  endtask

  logic       mv;
  logic       br;
  logic [2:0] st;
  logic [0:0] e;

  // Directed sequence.
  initial begin
    tests = 0; fails = 0; stray = 0;
    rst = 1'b1;
    bif.pixpulse = 1'b0; bif.hcount = 10'd1; bif.vcount = 10'd100;
    bif.xloc = 10'd320; bif.player = 1'b0;
    bif.broken0 = 1'b0; bif.broken1 = 1'b0; bif.start = 1'b0;
    repeat (3) step();

    check("rst_state",      bif.state_dbg,  S_IDLE);
    check("rst_ball_reset", bif.ball_reset, 1);
    check("rst_move",       bif.move,       0);
    check("rst_speed",      bif.speed,      128);
    check("rst_score0",     bif.score0,     0);
    check("rst_blocks0",    bif.blocks0,    0);
    check("rst_game_over",  bif.game_over,  0);
    check("rst_serve_pl",   bif.serve_player, 0);
    rst = 1'b0;
    step();

    // Start and serve: ball_reset falls exactly at the 60th tick.
    pulse_start();
    check("start_to_serve", bif.state_dbg, S_SERVE);
    repeat (3) begin
      bif.broken1 = 1'b1; step(); bif.broken1 = 1'b0; step();
    end
    check("broken1_in_serve", bif.blocks1, 0);
    serve_frames(59);
    check("serve59_ball_reset", bif.ball_reset, 1);
    check("serve59_state",      bif.state_dbg,  S_SERVE);
    frame(mv, st, br);
    check("serve60_state",      bif.state_dbg,  S_PLAY);
    check("serve60_ball_reset", bif.ball_reset, 0);

    // Speed 128: a move every second frame, starting with the second.
    for (int i = 0; i < 6; i++) exp_q.push_back(1'(i % 2));
    for (int i = 0; i < 6; i++) begin
      frame(mv, st, br);
      e = exp_q.pop_front();
      check($sformatf("play_move_f%0d", i), mv, e);
    end
    check("move_one_clk_only", stray, 0);

    pulse_start();
    check("start_ignored_play", bif.state_dbg, S_PLAY);

    // Rally speed-up and saturation.
    repeat (4)  begin bif.player = ~bif.player; step(); end
    check("speed_4_hits",  bif.speed, 144);
    repeat (24) begin bif.player = ~bif.player; step(); end
    check("speed_28_hits", bif.speed, 240);
    repeat (36) begin bif.player = ~bif.player; step(); end
    check("speed_64_hits", bif.speed, 255);

    // Block counts saturate.
    repeat (5) begin bif.broken0 = 1'b1; step(); bif.broken0 = 1'b0; step(); end
    check("blocks0_5", bif.blocks0, 5);
    repeat (295) begin bif.broken0 = 1'b1; step(); bif.broken0 = 1'b0; step(); end
    check("blocks0_sat", bif.blocks0, 255);

    // acc 0 -> 255 with no move, so the next frame has a move pending.
    frame(mv, st, br);
    check("speed255_frame_move", mv, 0);
    bif.xloc = 10'd3;
    frame(mv, st, br);
    check("goal_left_no_move",   mv, 0);
    check("goal_left_point",     st, S_POINT);
    check("goal_left_ball_rst2", br, 1);
    check("goal_left_state",     bif.state_dbg, S_SERVE);
    check("goal_left_score1",    bif.score1, 1);
    check("goal_left_serve_pl",  bif.serve_player, 0);
    bif.xloc = 10'd320;
    serve_frames(60);
    check("reserve_play",  bif.state_dbg, S_PLAY);
    check("reserve_speed", bif.speed, 128);

    // Player 0 wins 7-1.
    bif.xloc = 10'd636;
    for (int i = 0; i < 6; i++) begin
      frame(mv, st, br);
      serve_frames(60);
    end
    check("six_pts_score0",   bif.score0, 6);
    check("six_pts_score1",   bif.score1, 1);
    check("six_pts_serve_pl", bif.serve_player, 1);
    check("six_pts_state",    bif.state_dbg, S_PLAY);
    frame(mv, st, br);
    check("win_score0",    bif.score0, 7);
    check("win_game_over", bif.game_over, 1);
    check("win_winner",    bif.winner, 0);
    check("win_state",     bif.state_dbg, S_OVER);
    check("win_ball_rst",  bif.ball_reset, 1);
    bif.xloc = 10'd320;

    pulse_start();
    check("restart_state",   bif.state_dbg, S_SERVE);
    check("restart_score0",  bif.score0, 0);
    check("restart_score1",  bif.score1, 0);
    check("restart_blocks0", bif.blocks0, 0);
    check("restart_over",    bif.game_over, 0);
    check("restart_serve",   bif.serve_player, 0);

    serve_frames(60);
    check("play2_state", bif.state_dbg, S_PLAY);
    repeat (3) begin bif.broken1 = 1'b1; step(); bif.broken1 = 1'b0; step(); end
    check("blocks1_play", bif.blocks1, 3);
    frame(mv, st, br);
    check("play2_f0_move", mv, 0);
    check("no_stray_move", stray, 0);

    // Second frame issues a move; async reset lands while it is high.
    bif.pixpulse = 1'b1; bif.hcount = 10'd639; bif.vcount = 10'd479;
    step();
    bif.pixpulse = 1'b0;
    repeat (3) step();
    bif.pixpulse = 1'b1; bif.hcount = 10'd0; bif.vcount = 10'd480;
    step();
    bif.pixpulse = 1'b0; bif.hcount = 10'd1;
    check("pending_move_high", bif.move, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_move",    bif.move, 0);
    check("async_rst_state",   bif.state_dbg, S_IDLE);
    check("async_rst_ballrst", bif.ball_reset, 1);
    check("async_rst_blocks1", bif.blocks1, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", bif.state_dbg, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ball_game_ctrl.md
# ball_game_ctrl

Sequences play for the ball block: it generates the `move` strobe once per frame at a programmable speed and holds the ball in reset during serves. It also detects when the ball leaves the field, keeps both players' scores and broken-block counts, and runs the serve / play / game-over state machine. It sits beside the ball, fed by the VGA timing counters and the ball's status outputs, and drives the ball's `move` and `reset` inputs.

## Interface
- LEFT_GOAL, 10'd4: ball xloc strictly below this is a point for player 1
- RIGHT_GOAL, 10'd635: ball xloc strictly above this is a point for player 0
- FRAME_LINE, 10'd480: vcount value that marks end of visible frame
- SERVE_FRAMES, 8'd60: frames ball is held in reset before play
- SPEED_INIT, 8'd128: initial speed (moves per 256 frames)
- SPEED_STEP, 8'd16: speed increment per rally step
- RALLY_HITS, 4'd4: paddle touches per speed step
- WIN_SCORE, 4'd7: score that ends the game
- clk  in  1  100 MHz system clock
- rst  in  1  reset, asynchronous, active-high
- pixpulse  in  1  pixel-rate enable, 1 clk in 4
- hcount, vcount  in  10 each  scan position
- xloc  in  10  ball x-location
- player  in  1  last paddle to touch the ball
- broken0, broken1  in  1 each  block-broken pulses from ball
- start  in  1  synchronous start button, level
- move  out  1  one-clk strobe to ball, coincident with pixpulse
- ball_reset  out  1  level, holds ball at start position
- score0, score1  out  4 each  player scores
- blocks0, blocks1  out  8 each  blocks broken per player, saturating at 255
- speed  out  8  current speed value
- serve_player  out  1  loser of last point (0 after game start)
- game_over  out  1  high in OVER; winner  out  1  valid while game_over

## Operation
- frame_tick = pixpulse & hcount==0 & vcount==FRAME_LINE. All frame-based actions happen only on frame_tick.
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE: ball_reset=1. A rising edge of start (registered previous value) clears scores, block counts and serve_player, then goes to SERVE.
- SERVE: ball_reset=1, move=0. Serve counter loads SERVE_FRAMES on entry and decrements each frame_tick. At 0 → PLAY, ball_reset=0, speed=SPEED_INIT, accumulator=0, rally count=0.
- PLAY, on frame_tick, goal check first:
  - xloc<LEFT_GOAL → POINT, scoring player 1.
  - xloc>RIGHT_GOAL → POINT, scoring player 0.
  - Neither: acc9 = {1'b0,acc}+speed; move=acc9[8]; acc=acc9[7:0].
  - No move is issued on the frame a goal is detected.
- PLAY, every clk: a change in player (register compare) increments the rally count. When the count reaches RALLY_HITS: speed = min(speed+SPEED_STEP, 255) and the count resets to 0.
- PLAY only: a broken0/broken1 pulse increments blocks0/blocks1, saturating at 255. Pulses are ignored in other states.
- POINT (one clk):
  - Increment the scorer's score.
  - serve_player = the other player.
  - New score == WIN_SCORE → OVER, winner=scorer. Otherwise → SERVE.
- OVER: ball_reset=1, game_over=1. A start rising edge behaves as in IDLE.
- start edges in SERVE/PLAY/POINT are ignored.

## Timing
- Reset values:
  - state IDLE, ball_reset 1, move 0.
  - scores, blocks, acc, rally count, serve counter, serve_player, winner, game_over all 0.
  - speed SPEED_INIT.
- All outputs are registered.
- move rises on the clk after the frame_tick clk, for exactly 1 clk, and must still coincide with a pixpulse. Implement this by evaluating move on the pixpulse immediately preceding frame_tick (hcount==639, vcount==FRAME_LINE-1, with registered lookahead), so move and frame_tick share one pixpulse.
- At most one move per frame. speed=255 gives 255 moves per 256 frames.
- Goal detected on frame_tick: POINT on the next clk, then SERVE or OVER on the clk after; ball_reset is high 2 clks after the tick.
- SERVE lasts SERVE_FRAMES frame_ticks (SERVE_FRAMES=0 behaves as 256).
- rst mid-game returns everything to reset values immediately (asynchronous).

## Test plan
- Reset, pulse start, run 60 frames → ball_reset falls at frame 60. With SPEED_INIT=128, move pulses on every 2nd frame; each pulse is 1 clk and aligned with pixpulse.
- Force xloc=3 in PLAY → no move that frame, score1=1, serve_player=0, ball_reset=1 within 2 clks, SERVE restarts.
- Toggle player 4 times → speed 128→144. Toggle 60 more times → speed saturates at 255; never wraps.
- Six points to player 0, then xloc=636 → score0=7, game_over=1, winner=0. A start edge clears scores to 0 and enters SERVE.
- 300 broken0 pulses in PLAY → blocks0=255. broken1 pulses in SERVE → blocks1 unchanged.
- Assert rst mid-PLAY with move pending → move=0, state IDLE, ball_reset=1 immediately; start edges while in PLAY are ignored.
